// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and helpers for the keypad scanner: FSM and frame-result encodings, idle key code, digit table.
// Pure declarations, no timing or flow control of its own.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } kp_state_e;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_res_e;

    localparam int CNT_W = 4;
    localparam logic [15:0] KEY_NONE = 16'hFFFF;

    // 4x3 phone layout: top three rows are 1..9, bottom row is *, 0, #
    function automatic logic [3:0] phone_map(input logic [3:0] idx);
        logic [3:0] code;
        code = idx;
        if (idx <= 4'd8) begin
            code = idx + 4'd1;
        end else if (idx == 4'd9) begin
            code = 4'd10;
        end else if (idx == 4'd10) begin
            code = 4'd0;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Key-event handshake between the scanner (master) and the game FSM (slave).
// key_valid/key_code hold until accepted with key_ready; overrun is a one-cycle pulse.
interface keypad_scan_ctrl_if #(
    parameter int KEY_W = 4
);
    logic             key_valid;
    logic [KEY_W-1:0] key_code;
    logic             key_ready;
    logic             key_down;
    logic             overrun;

    modport master (
        output key_valid,
        output key_code,
        output key_down,
        output overrun,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  key_down,
        input  overrun,
        output key_ready
    );
endinterface

// File: rtl/keypad_scan_ctrl_tick.sv
// Row-dwell divider: tick is high for one cycle every DIV cycles, combinational from the count.
// clr holds the counter at zero and suppresses tick; no backpressure.
module scan_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = !clr && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: one active-low row per dwell, frame-level debounce, ghost rejection, one event per press.
// key_valid rises the edge after the debouncing frame close; a press arriving while an event is unaccepted is dropped with overrun.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 3,
    parameter int SCAN_DIV  = 50000,
    parameter int DEBOUNCE  = 4,
    parameter int PHONE_MAP = 1,
    parameter int KEY_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [COLS-1:0]    col_n,
    output logic [ROWS-1:0]    row_n,
    keypad_scan_ctrl_if.master key
);
    localparam int PTR_W = $clog2(ROWS);
    localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE);
    localparam logic [KEY_W-1:0] CODE_IDLE = KEY_W'(KEY_NONE);

    logic             tick;
    logic             frame_close;
    logic [PTR_W-1:0] ptr, ptr_nxt;

    logic [1:0]       row_lows, acc_lows, tot_lows;
    logic [KEY_W-1:0] row_idx, acc_idx, tot_idx;
    frame_res_e       frame_res;

    kp_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [KEY_W-1:0] cand, cand_nxt;
    logic [KEY_W-1:0] emit_idx, mapped;
    logic             press_evt;

    logic             valid_q, overrun_q;
    logic [KEY_W-1:0] code_q;

    scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (~enable),
        .tick (tick)
    );

    assign frame_close = tick && (ptr == PTR_W'(ROWS - 1));

    always_comb begin
        ptr_nxt = ptr;
        if (tick) begin
            ptr_nxt = (ptr == PTR_W'(ROWS - 1)) ? '0 : ptr + 1'b1;
        end
    end

    // Count lows in the current row, saturating at two; remember the first one's index
    always_comb begin
        row_lows = 2'd0;
        row_idx  = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!col_n[c]) begin
                if (row_lows == 2'd0) begin
                    row_idx  = KEY_W'(int'(ptr) * COLS + c);
                    row_lows = 2'd1;
                end else begin
                    row_lows = 2'd2;
                end
            end
        end
    end

    always_comb begin
        tot_idx = (acc_lows != 2'd0) ? acc_idx : row_idx;
        if (acc_lows == 2'd0) begin
            tot_lows = row_lows;
        end else if (row_lows == 2'd0) begin
            tot_lows = acc_lows;
        end else begin
            tot_lows = 2'd2;
        end
        case (tot_lows)
            2'd0:    frame_res = NONE;
            2'd1:    frame_res = SINGLE;
            default: frame_res = MULTI;
        endcase
    end

    // row_n follows the next pointer so drive and pointer change on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            row_n    <= '1;
            acc_lows <= 2'd0;
            acc_idx  <= '0;
        end else if (!enable) begin
            ptr      <= '0;
            row_n    <= '1;
            acc_lows <= 2'd0;
            acc_idx  <= '0;
        end else begin
            ptr   <= ptr_nxt;
            row_n <= ~(ROWS'(1) << ptr_nxt);
            if (frame_close) begin
                acc_lows <= 2'd0;
                acc_idx  <= '0;
            end else if (tick) begin
                acc_lows <= tot_lows;
                acc_idx  <= tot_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        emit_idx  = cand;
        press_evt = 1'b0;
        if (frame_close) begin
            case (state)
                IDLE: begin
                    if (frame_res == SINGLE) begin
                        cand_nxt = tot_idx;
                        emit_idx = tot_idx;
                        if (DEBOUNCE == 1) begin
                            state_nxt = HELD;
                            cnt_nxt   = '0;
                            press_evt = 1'b1;
                        end else begin
                            state_nxt = PRESS_DB;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                PRESS_DB: begin
                    if (frame_res == SINGLE && tot_idx == cand) begin
                        if (cnt + 1'b1 == DEB_C) begin
                            state_nxt = HELD;
                            cnt_nxt   = '0;
                            press_evt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                HELD: begin
                    if (frame_res == NONE) begin
                        if (DEBOUNCE == 1) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = REL_DB;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (frame_res == NONE) begin
                        if (cnt + 1'b1 == DEB_C) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end else begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end
                end
            endcase
        end
    end

    generate
        if (PHONE_MAP != 0) begin : g_phone
            assign mapped = KEY_W'(phone_map(4'(emit_idx)));
        end else begin : g_raw
            assign mapped = emit_idx;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            code_q    <= CODE_IDLE;
            overrun_q <= 1'b0;
        end else if (!enable) begin
            valid_q   <= 1'b0;
            code_q    <= CODE_IDLE;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (press_evt) begin
                if (!valid_q || key.key_ready) begin
                    valid_q <= 1'b1;
                    code_q  <= mapped;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (key.key_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign key.key_valid = valid_q;
    assign key.key_code  = code_q;
    assign key.overrun   = overrun_q;
    assign key.key_down  = (state == HELD) || (state == REL_DB);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: expected key codes are queued by stimulus, a negedge monitor pops them on accept.
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, enable_r;
    logic [2:0]  col_n, col_n_r;
    logic [3:0]  row_n, row_n_r;
    logic [11:0] keys, keys_r;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int exp_q[$];
    int exp_q_r[$];
    int n;

    always #5 clk = ~clk;

    keypad_scan_ctrl_if #(.KEY_W(4)) kif ();
    keypad_scan_ctrl_if #(.KEY_W(4)) kif_r ();

    keypad_scan_ctrl #(
        .ROWS(4), .COLS(3), .SCAN_DIV(4), .DEBOUNCE(2), .PHONE_MAP(1), .KEY_W(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .col_n(col_n), .row_n(row_n), .key(kif)
    );

    keypad_scan_ctrl #(
        .ROWS(4), .COLS(3), .SCAN_DIV(4), .DEBOUNCE(1), .PHONE_MAP(0), .KEY_W(4)
    ) dut_raw (
        .clk(clk), .rst(rst), .enable(enable_r), .col_n(col_n_r), .row_n(row_n_r), .key(kif_r)
    );

    // Passive switch matrix: a pressed key shorts its column to a driven-low row
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!row_n[r] && keys[r*3+c]) col_n[c] = 1'b0;
    end

    always_comb begin
        col_n_r = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!row_n_r[r] && keys_r[r*3+c]) col_n_r[c] = 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    logic       hold_pend = 1'b0;
    logic [3:0] held_code = 4'h0;
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (kif.overrun) ovr_cnt++;
            if (hold_pend && kif.key_valid)
                chk("hold_stable", int'(kif.key_code), int'(held_code));
            if (kif.key_valid && kif.key_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_key: got %0d expected none", kif.key_code);
                end else begin
                    chk("key_code", int'(kif.key_code), exp_q.pop_front());
                end
            end
            hold_pend = kif.key_valid && !kif.key_ready;
            held_code = kif.key_code;
            if (kif_r.key_valid && kif_r.key_ready) begin
                if (exp_q_r.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_raw_key: got %0d expected none", kif_r.key_code);
                end else begin
                    chk("raw_key_code", int'(kif_r.key_code), exp_q_r.pop_front());
                end
            end
        end
    end

    // Returns at the first negedge of row 0 following row 3
    task automatic sync_frame(input bit raw);
        logic [3:0] prev, cur;
        bit found;
        found = 1'b0;
        prev = raw ? row_n_r : row_n;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            cur = raw ? row_n_r : row_n;
            if (cur == 4'b1110 && prev == 4'b0111) found = 1'b1;
            prev = cur;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL sync_timeout: got no frame start expected one within 200 cycles");
        end
    endtask

    task automatic wait_valid(input bit raw, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(raw ? kif_r.key_valid : kif.key_valid) && cyc < 200);
    endtask

    task automatic chk_reset_vals();
        chk("rst_row_n", int'(row_n), 15);
        chk("rst_key_valid", int'(kif.key_valid), 0);
        chk("rst_key_code", int'(kif.key_code), 15);
        chk("rst_key_down", int'(kif.key_down), 0);
        chk("rst_overrun", int'(kif.overrun), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_row;
        rst = 1'b1; enable = 1'b0; enable_r = 1'b0; keys = '0; keys_r = '0;
        kif.key_ready = 1'b1; kif_r.key_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0; enable = 1'b1; enable_r = 1'b1;

        // Idle scan order, 4 clks per row
        sync_frame(0);
        for (int i = 0; i < 4; i++) begin
            exp_row = ~(4'b0001 << i);
            chk("row_scan", int'(row_n), int'(exp_row));
            chk("idle_valid", int'(kif.key_valid), 0);
            repeat (4) @(negedge clk);
        end

        // Clean press of key 5 held three frames
        sync_frame(0);
        keys = 12'h010; exp_q.push_back(5);
        wait_valid(0, n); chk("press_latency", n, 32);
        repeat (16) @(negedge clk);
        chk("held_down", int'(kif.key_down), 1);
        keys = '0;
        repeat (48) @(negedge clk);
        chk("released_down", int'(kif.key_down), 0);
        chk("single_event", exp_q.size(), 0);

        // Bounce: present, absent, present, present
        sync_frame(0);
        keys = 12'h010; exp_q.push_back(5);
        repeat (16) @(negedge clk); keys = '0;
        repeat (16) @(negedge clk); keys = 12'h010;
        wait_valid(0, n); chk("bounce_latency", n, 32);
        repeat (16) @(negedge clk); keys = '0;
        repeat (48) @(negedge clk);
        chk("bounce_single", exp_q.size(), 0);

        // Two keys together are ghosted; the survivor is reported
        sync_frame(0);
        keys = 12'h101;
        repeat (48) @(negedge clk);
        chk("ghost_down", int'(kif.key_down), 0);
        keys = 12'h001; exp_q.push_back(1);
        wait_valid(0, n); chk("ghost_survivor_latency", n, 32);
        repeat (16) @(negedge clk); keys = '0;
        repeat (48) @(negedge clk);

        // Overrun: second press while first unaccepted
        kif.key_ready = 1'b0;
        sync_frame(0);
        keys = 12'h001; exp_q.push_back(1);
        repeat (48) @(negedge clk);
        chk("pending_valid", int'(kif.key_valid), 1);
        chk("pending_code", int'(kif.key_code), 1);
        keys = '0;
        repeat (48) @(negedge clk);
        keys = 12'h002;
        repeat (48) @(negedge clk);
        chk("overrun_pulses", ovr_cnt, 1);
        chk("overrun_code_kept", int'(kif.key_code), 1);
        keys = '0;
        repeat (48) @(negedge clk);
        @(posedge clk); #1 kif.key_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("accept_drops_valid", int'(kif.key_valid), 0);
        chk("overrun_total", ovr_cnt, 1);

        // Phone map: row3/col1 is digit 0
        sync_frame(0);
        keys = 12'h400; exp_q.push_back(0);
        wait_valid(0, n); chk("phone_latency", n, 32);
        repeat (16) @(negedge clk); keys = '0;
        repeat (48) @(negedge clk);

        // Enable drop mid-debounce
        sync_frame(0);
        keys = 12'h010;
        repeat (20) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_row_n", int'(row_n), 15);
        chk("dis_valid", int'(kif.key_valid), 0);
        chk("dis_code", int'(kif.key_code), 15);
        chk("dis_down", int'(kif.key_down), 0);
        keys = '0;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        chk("restart_row0", int'(row_n), 14);
        repeat (64) @(negedge clk);
        chk("dis_no_event", exp_q.size(), 0);

        // Reset while HELD
        sync_frame(0);
        keys = 12'h010; exp_q.push_back(5);
        repeat (48) @(negedge clk);
        chk("pre_rst_down", int'(kif.key_down), 1);
        rst = 1'b1;
        #1;
        chk_reset_vals();
        keys = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (32) @(negedge clk);

        // Raw mapping with single-frame debounce
        sync_frame(1);
        keys_r = 12'h400; exp_q_r.push_back(10);
        wait_valid(1, n); chk("raw_latency", n, 16);
        chk("raw_down", int'(kif_r.key_down), 1);
        repeat (16) @(negedge clk); keys_r = '0;
        repeat (16) @(negedge clk);
        chk("raw_release", int'(kif_r.key_down), 0);
        keys_r = 12'h001; exp_q_r.push_back(0);
        wait_valid(1, n); chk("raw_latency2", n, 16);
        keys_r = '0;
        repeat (32) @(negedge clk);

        chk("queue_drained", exp_q.size(), 0);
        chk("raw_queue_drained", exp_q_r.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Parametrised matrix-keypad scanner and decoder feeding the game FSM with debounced key codes. Drives one active-low row at a time and samples active-low columns. Reports each debounced press exactly once through a valid/ready handshake. Adds configurable matrix size, multi-frame debounce, release detection, ghost (multi-key) rejection and overrun flagging.

Parameters:
ROWS, 4, number of keypad rows (2..8)
COLS, 3, number of keypad columns (2..8)
SCAN_DIV, 50000, clk cycles per row dwell (>=2)
DEBOUNCE, 4, consecutive identical frames required for press and for release (1..15)
PHONE_MAP, 1, 1: phone-style digit mapping (valid only for ROWS=4, COLS=3); 0: raw index
KEY_W, 4, key_code width; must satisfy 2**KEY_W >= ROWS*COLS

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  scanning allowed (game FSM in input state)
col_n  in  COLS  column sense lines, active low, pre-synchronised externally
row_n  out  ROWS  row drive lines, exactly one low while scanning
key_valid  out  1  key_code holds an unconsumed press
key_code  out  KEY_W  decoded key
key_ready  in  1  consumer accepts key_code this cycle
key_down  out  1  level: debounced key currently held
overrun  out  1  one-cycle pulse: press discarded because key_valid was pending

Behaviour:
- Reset: row_n all ones, key_valid 0, key_code all ones, key_down 0, overrun 0, row pointer 0, FSM IDLE, debounce count 0.
- Tick: scan_tick_gen pulses once every SCAN_DIV clk cycles. On tick, sample col_n for the current row, then advance the row pointer (ROWS-1 wraps to 0). row_n is registered from the pointer.
- Frame: ROWS ticks. At the frame-closing tick (pointer ROWS-1) the frame result is NONE, SINGLE(idx = row*COLS + col) or MULTI (two or more lows anywhere).
- FSM, evaluated only at frame close:
  - IDLE: SINGLE -> PRESS_DB with candidate=idx, cnt=1. Otherwise stay.
  - PRESS_DB: SINGLE with the same idx -> cnt+1. Any other result -> IDLE. When cnt reaches DEBOUNCE -> HELD and a press event is emitted.
  - HELD: NONE -> REL_DB with cnt=1. SINGLE or MULTI -> stay (held/ghost ignored).
  - REL_DB: NONE -> cnt+1; reaching DEBOUNCE -> IDLE. Anything else -> HELD.
  - DEBOUNCE=1: press is emitted on the first SINGLE frame, and release occurs on the first NONE frame.
- key_down: 1 in HELD and REL_DB, else 0.
- Press event latency: key_valid rises on the clk edge after the frame-close tick that completes debounce.
- Mapping with PHONE_MAP=1: idx 0..8 -> 1..9, idx 9 (*) -> 10, idx 10 -> 0, idx 11 (#) -> 11. With PHONE_MAP=0: code = idx.
- Handshake:
  - key_valid and key_code hold stable until a clk edge with key_ready=1; on that edge key_valid drops to 0.
  - key_ready while key_valid=0 has no effect.
- Press event while key_valid=1 and key_ready=0: event discarded, overrun pulses 1 cycle, old code kept.
- Press event and accept on the same edge: new code loaded, key_valid stays 1, no overrun.
- enable low:
  - Synchronously: row_n all ones, FSM IDLE, cnt 0, row pointer 0, tick counter cleared, key_valid 0, key_code all ones.
  - Scanning restarts at row 0 when enable rises.
- Reset mid-frame: immediate return to reset values; no partial event is emitted.

Decomposition:
- Package keypad_pkg holds:
  - FSM enum (IDLE, PRESS_DB, HELD, REL_DB) and frame-result enum (NONE, SINGLE, MULTI)
  - constant KEY_NONE = all ones
  - function phone_map(idx) returning the 4x3 digit table
- Sub-module scan_tick_gen (params DIV; ports clk, rst, clr, tick) for the dwell divider.

Test Plan:
- Reset, enable=1, SCAN_DIV=4, no keys -> row_n cycles 1110,1101,1011,0111 every 4 clks; key_valid stays 0.
- DEBOUNCE=2, hold row1/col1 low for 3 frames -> key_valid=1 with key_code=5 one clk after 2nd frame close; key_down=1; exactly one event.
- Bounce: key seen in frame 1, absent in frame 2, present in frames 3-4 -> single event, code 5, after frame 4.
- Two keys (row0/col0 and row2/col2) together from IDLE -> no event; after releasing one, the remaining key is reported after DEBOUNCE frames.
- key_ready=0; press 1, release, press 2 -> key_code stays 1, overrun pulses once; then key_ready=1 -> key_valid falls.
- Press row3/col1 with PHONE_MAP=1 -> code 0, PHONE_MAP=0 -> code 10. Drop enable mid-debounce -> row_n=all ones, no event. Assert rst in HELD -> all outputs at reset values.
